// File: rtl/tdm_demux_1a4.sv
// rtl/tdm_demux_1a4.sv - 1:4 time-division demultiplexer with frame sync hunting
module tdm_demux_1a4 #(
    parameter int W = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           din_valid,
    input  logic [W-1:0]   din,
    input  logic           sof,
    output logic [4*W-1:0] y,
    output logic [1:0]     s,
    output logic           frame_valid,
    output logic           sync_err,
    output logic           locked
);

    typedef enum logic {
        ST_HUNT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [1:0]     s_q, s_d;
    logic [3*W-1:0] shadow_q, shadow_d;
    logic [4*W-1:0] y_q, y_d;
    logic           frame_valid_q, frame_valid_d;
    logic           sync_err_q, sync_err_d;

    // State register: FSM state, slot counter, shadow lanes, published frame and pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_HUNT;
            s_q           <= 2'd0;
            shadow_q      <= '0;
            y_q           <= '0;
            frame_valid_q <= 1'b0;
            sync_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            s_q           <= s_d;
            shadow_q      <= shadow_d;
            y_q           <= y_d;
            frame_valid_q <= frame_valid_d;
            sync_err_q    <= sync_err_d;
        end
    end

    // Next-state logic: slot routing, frame publish and resync decisions
    always_comb begin
        state_d       = state_q;
        s_d           = s_q;
        shadow_d      = shadow_q;
        y_d           = y_q;
        frame_valid_d = 1'b0;
        sync_err_d    = 1'b0;

        if (din_valid) begin
            case (state_q)
                ST_HUNT: begin
                    // Non-sof samples are dropped silently while hunting
                    if (sof) begin
                        shadow_d[W-1:0] = din;
                        s_d             = 2'd1;
                        state_d         = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (sof) begin
                        // sof mid-frame abandons the partial frame but resyncs at once
                        sync_err_d      = (s_q != 2'd0);
                        shadow_d[W-1:0] = din;
                        s_d             = 2'd1;
                    end else begin
                        case (s_q)
                            2'd0: begin
                                // Missing sof where slot 0 was due: lose lock
                                sync_err_d = 1'b1;
                                s_d        = 2'd0;
                                state_d    = ST_HUNT;
                            end
                            2'd1: begin
                                shadow_d[W +: W] = din;
                                s_d              = 2'd2;
                            end
                            2'd2: begin
                                shadow_d[2*W +: W] = din;
                                s_d                = 2'd3;
                            end
                            default: begin
                                y_d           = {din, shadow_q};
                                frame_valid_d = 1'b1;
                                s_d           = 2'd0;
                            end
                        endcase
                    end
                end
                default: begin
                    state_d = ST_HUNT;
                    s_d     = 2'd0;
                end
            endcase
        end
    end

    // Output logic: every output comes straight from a register
    always_comb begin
        y           = y_q;
        s           = s_q;
        frame_valid = frame_valid_q;
        sync_err    = sync_err_q;
        locked      = (state_q == ST_RUN);
    end

endmodule

// File: tb/tb_tdm_demux_1a4.sv
// tb/tb_tdm_demux_1a4.sv - directed self-checking bench for tdm_demux_1a4
module tb_tdm_demux_1a4;

    localparam int W = 8;

    logic           clk;
    logic           rst;
    logic           din_valid;
    logic [W-1:0]   din;
    logic           sof;
    logic [4*W-1:0] y;
    logic [1:0]     s;
    logic           frame_valid;
    logic           sync_err;
    logic           locked;

    int n_cmp;
    int n_err;
    int fv_cnt;
    int se_cnt;
    int cyc_idx;
    int fv_at [$];

    tdm_demux_1a4 #(.W(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .din_valid   (din_valid),
        .din         (din),
        .sof         (sof),
        .y           (y),
        .s           (s),
        .frame_valid (frame_valid),
        .sync_err    (sync_err),
        .locked      (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle, sample 1ns after the edge, tally pulses
    task automatic cyc(input logic v, input logic f, input logic [W-1:0] d);
        din_valid = v;
        sof       = f;
        din       = d;
        @(posedge clk);
        #1;
        cyc_idx++;
        if (frame_valid) begin
            fv_cnt++;
            fv_at.push_back(cyc_idx);
        end
        if (sync_err) se_cnt++;
        n_cmp++;
        if (frame_valid && sync_err) begin
            n_err++;
            $display("FAIL pulse_exclusive: frame_valid=%0b sync_err=%0b required not both 1", frame_valid, sync_err);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(1'b0, 1'b0, 8'h00);
        rst = 1'b0;
        fv_cnt = 0;
        se_cnt = 0;
        fv_at.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc(1'b1, 1'b1, 8'hFF);
        rst = 1'b0;
        n_cmp++;
        if (y !== 32'h0 || s !== 2'd0 || frame_valid !== 1'b0 || sync_err !== 1'b0 || locked !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: y=%h s=%0d fv=%0b se=%0b lk=%0b required all 0", y, s, frame_valid, sync_err, locked);
        end
    endtask

    task automatic test_basic();
        do_reset();
        cyc(1'b1, 1'b1, 8'h11);
        n_cmp++;
        if (locked !== 1'b1 || s !== 2'd1) begin
            n_err++;
            $display("FAIL basic_lock: locked=%0b s=%0d required 1 1", locked, s);
        end
        cyc(1'b1, 1'b0, 8'h22);
        cyc(1'b1, 1'b0, 8'h33);
        n_cmp++;
        if (frame_valid !== 1'b0 || y !== 32'h0) begin
            n_err++;
            $display("FAIL basic_early: fv=%0b y=%h required 0 00000000", frame_valid, y);
        end
        cyc(1'b1, 1'b0, 8'h44);
        n_cmp++;
        if (y !== 32'h44332211 || frame_valid !== 1'b1 || s !== 2'd0) begin
            n_err++;
            $display("FAIL basic_frame: y=%h fv=%0b s=%0d required 44332211 1 0", y, frame_valid, s);
        end
        cyc(1'b0, 1'b0, 8'h00);
        n_cmp++;
        if (frame_valid !== 1'b0 || y !== 32'h44332211 || locked !== 1'b1) begin
            n_err++;
            $display("FAIL basic_hold: fv=%0b y=%h lk=%0b required 0 44332211 1", frame_valid, y, locked);
        end
    endtask

    task automatic test_gaps();
        logic [W-1:0] smp [4];
        smp[0] = 8'h11; smp[1] = 8'h22; smp[2] = 8'h33; smp[3] = 8'h44;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, (i == 0), smp[i]);
            if (i < 3) begin
                for (int g = 0; g < 2; g++) begin
                    cyc(1'b0, 1'b0, 8'hEE);
                    n_cmp++;
                    if (s !== 2'(i + 1)) begin
                        n_err++;
                        $display("FAIL gap_s_hold: s=%0d required %0d", s, i + 1);
                    end
                end
            end
        end
        cyc(1'b0, 1'b0, 8'h00);
        n_cmp++;
        if (y !== 32'h44332211 || fv_cnt !== 1) begin
            n_err++;
            $display("FAIL gap_frame: y=%h fv_count=%0d required 44332211 1", y, fv_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] smp [8];
        smp[0] = 8'h11; smp[1] = 8'h22; smp[2] = 8'h33; smp[3] = 8'h44;
        smp[4] = 8'hA0; smp[5] = 8'hA1; smp[6] = 8'hA2; smp[7] = 8'hA3;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, (i == 0 || i == 4), smp[i]);
            if (i >= 4 && i <= 6) begin
                n_cmp++;
                if (y !== 32'h44332211) begin
                    n_err++;
                    $display("FAIL b2b_hold: y=%h required 44332211", y);
                end
            end
        end
        n_cmp++;
        if (y !== 32'hA3A2A1A0) begin
            n_err++;
            $display("FAIL b2b_second: y=%h required a3a2a1a0", y);
        end
        n_cmp++;
        if (fv_at.size() != 2) begin
            n_err++;
            $display("FAIL b2b_count: fv_count=%0d required 2", fv_at.size());
        end else if (fv_at[1] - fv_at[0] != 4) begin
            n_err++;
            $display("FAIL b2b_spacing: spacing=%0d required 4", fv_at[1] - fv_at[0]);
        end
    endtask

    task automatic test_misalign();
        do_reset();
        cyc(1'b1, 1'b1, 8'h11);
        cyc(1'b1, 1'b0, 8'h22);
        cyc(1'b1, 1'b0, 8'h33);
        cyc(1'b1, 1'b0, 8'h44);
        se_cnt = 0;
        fv_cnt = 0;
        cyc(1'b1, 1'b0, 8'h55);
        n_cmp++;
        if (sync_err !== 1'b1 || locked !== 1'b0 || s !== 2'd0) begin
            n_err++;
            $display("FAIL mis_err: se=%0b lk=%0b s=%0d required 1 0 0", sync_err, locked, s);
        end
        cyc(1'b1, 1'b0, 8'h66);
        n_cmp++;
        if (sync_err !== 1'b0 || locked !== 1'b0) begin
            n_err++;
            $display("FAIL mis_hunt_discard: se=%0b lk=%0b required 0 0", sync_err, locked);
        end
        cyc(1'b1, 1'b1, 8'h01);
        n_cmp++;
        if (locked !== 1'b1) begin
            n_err++;
            $display("FAIL mis_relock: locked=%0b required 1", locked);
        end
        cyc(1'b1, 1'b0, 8'h02);
        cyc(1'b1, 1'b0, 8'h03);
        cyc(1'b1, 1'b0, 8'h04);
        n_cmp++;
        if (y !== 32'h04030201 || frame_valid !== 1'b1 || fv_cnt !== 1 || se_cnt !== 1) begin
            n_err++;
            $display("FAIL mis_frame: y=%h fv=%0b fv_count=%0d se_count=%0d required 04030201 1 1 1",
                     y, frame_valid, fv_cnt, se_cnt);
        end
    endtask

    task automatic test_early_sof();
        do_reset();
        cyc(1'b1, 1'b1, 8'h11);
        cyc(1'b1, 1'b0, 8'h22);
        cyc(1'b1, 1'b1, 8'h77);
        n_cmp++;
        if (sync_err !== 1'b1 || y !== 32'h0 || s !== 2'd1 || locked !== 1'b1) begin
            n_err++;
            $display("FAIL early_err: se=%0b y=%h s=%0d lk=%0b required 1 00000000 1 1", sync_err, y, s, locked);
        end
        cyc(1'b1, 1'b0, 8'h88);
        cyc(1'b1, 1'b0, 8'h99);
        cyc(1'b1, 1'b0, 8'hAA);
        n_cmp++;
        if (y !== 32'hAA998877 || frame_valid !== 1'b1 || fv_cnt !== 1 || se_cnt !== 1) begin
            n_err++;
            $display("FAIL early_frame: y=%h fv=%0b fv_count=%0d se_count=%0d required aa998877 1 1 1",
                     y, frame_valid, fv_cnt, se_cnt);
        end
    endtask

    task automatic test_rst_mid();
        do_reset();
        cyc(1'b1, 1'b1, 8'h11);
        cyc(1'b1, 1'b0, 8'h22);
        cyc(1'b1, 1'b0, 8'h33);
        rst = 1'b1;
        cyc(1'b1, 1'b0, 8'h44);
        rst = 1'b0;
        n_cmp++;
        if (y !== 32'h0 || s !== 2'd0 || frame_valid !== 1'b0 || sync_err !== 1'b0 || locked !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid_state: y=%h s=%0d fv=%0b se=%0b lk=%0b required all 0", y, s, frame_valid, sync_err, locked);
        end
        cyc(1'b1, 1'b0, 8'h44);
        n_cmp++;
        if (y !== 32'h0 || s !== 2'd0 || frame_valid !== 1'b0 || sync_err !== 1'b0 || locked !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid_hunt: y=%h s=%0d fv=%0b se=%0b lk=%0b required all 0", y, s, frame_valid, sync_err, locked);
        end
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        fv_cnt    = 0;
        se_cnt    = 0;
        cyc_idx   = 0;
        rst       = 1'b1;
        din_valid = 1'b0;
        din       = '0;
        sof       = 1'b0;
        test_reset();
        test_basic();
        test_gaps();
        test_back_to_back();
        test_misalign();
        test_early_sof();
        test_rst_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/tdm_demux_1a4.md
# tdm_demux_1a4

Time-division demultiplexer: the receive-side counterpart of the 4:1 multiplexers in `src/multiplexers`. It accepts a serial stream of W-bit samples, one per valid cycle, in frames of four slots marked by a start-of-frame flag. It routes slot i to output lane i and publishes the four lanes atomically, with a one-cycle `frame_valid` pulse, once slot 3 arrives. It also detects frame misalignment and re-hunts for sync.

## Interface
- `W`, default 1: sample width per slot, in bits (≥1).

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `din_valid`  in  1  `din`/`sof` carry a sample this cycle.
- `din`  in  W  sample data.
- `sof`  in  1  start of frame; qualified by `din_valid`; marks slot 0.
- `y`  out  4*W  published frame; lane i = `y[i*W +: W]`; held between frames.
- `s`  out  2  slot index expected for the next accepted sample.
- `frame_valid`  out  1  one-cycle pulse: `y` has just been updated.
- `sync_err`  out  1  one-cycle pulse: misalignment detected.
- `locked`  out  1  high while FSM is in RUN.

## Operation
- Internal state:
  - FSM states HUNT and RUN.
  - 2-bit slot counter `s`.
  - Shadow buffer of lanes 0..2 (3*W bits).
  - Output register `y`.
- Reset: state HUNT, `s`=0, shadow=0, `y`=0, `frame_valid`=0, `sync_err`=0, `locked`=0.
- `din_valid`=0: no state change. Pulses drop to 0. `y` and `s` hold.
- HUNT:
  - `din_valid`=1 & `sof`=0: sample discarded. No error; stay in HUNT.
  - `din_valid`=1 & `sof`=1: `din` goes to shadow lane 0, `s`←1, move to RUN.
- RUN, `din_valid`=1:
  - `s`=0 & `sof`=1: capture lane 0, `s`←1.
  - `s`=0 & `sof`=0: `sync_err` pulse. Sample discarded; go to HUNT; `s`←0.
  - `s`∈{1,2} & `sof`=0: capture into shadow lane `s`, `s`←`s`+1.
  - `s`=3 & `sof`=0:
    - `y` ← {`din`, shadow2, shadow1, shadow0}.
    - `frame_valid` pulses.
    - `s` wraps to 0; stay in RUN.
  - `s`∈{1,2,3} & `sof`=1 (early sof):
    - `sync_err` pulses.
    - Partial frame discarded; `y` unchanged.
    - `din` captured as lane 0, `s`←1; stay in RUN (immediate resync).
- `y` changes only on a completed frame. A partial frame never reaches `y`.
- `locked` = (state==RUN).
- `frame_valid` and `sync_err` are never high together.

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- Latency: the slot-3 sample accepted at edge k produces `y` updated and `frame_valid`=1 during cycle k+1.
- Back-to-back frames: 4 consecutive valid cycles per frame, so `frame_valid` fires at most every 4th cycle. Gaps (`din_valid`=0) are allowed anywhere within a frame.
- `sync_err`: high the cycle after the offending sample is accepted.
- `rst` mid-frame: at the next edge, the partial frame is lost and all outputs return to reset values, including `y`=0.
- `rst` has priority over `din_valid` in the same cycle.

## Test plan (W=8)
- Reset, then feed `sof`+0x11, 0x22, 0x33, 0x44 on consecutive cycles:
  - `y`=0x44332211 and `frame_valid`=1 exactly one cycle after 0x44.
  - `locked`=1 from the cycle after 0x11.
- Same frame with `din_valid` low for 2 cycles between each sample: identical `y`; single `frame_valid`; `s` holds during gaps.
- Two back-to-back frames (0x11..0x44, then `sof`+0xA0..0xA3):
  - `frame_valid` pulses 4 cycles apart.
  - `y`=0xA3A2A1A0 after the second frame.
  - `y` keeps 0x44332211 in between.
- After one good frame, send 0x55, 0x66, then `sof`+0x01, 0x02, 0x03, 0x04:
  - Leading 0x55: `sync_err` pulse, FSM to HUNT. 0x66: discarded, no error.
  - `sof` frame: relock; `y`=0x04030201 with one `frame_valid`.
- Early `sof`: send `sof`+0x11, 0x22, then `sof`+0x77, 0x88, 0x99, 0xAA:
  - `sync_err` pulses once; `y` stays 0.
  - `y`=0xAA998877 with one `frame_valid`.
- Assert `rst` after slot 2 of a frame, then send slot 3 without `sof`:
  - All outputs read 0; sample ignored in HUNT; no `frame_valid`, no `sync_err`.
